sobel_row_window: RTL and testbench

//  Upstream feeder of the Sobel accelerator core. Accepts image rows (one SOBEL_IDATA_WIDTH word per row
//  of the current column strip) from the memory read path and holds a sliding 3-row window.

---
 rtl/sobel_row_window.sv | 146 ++++++++++++++
 tb/tb_sobel_row_window.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_row_window.sv
// Sliding 3-row window feeder for the Sobel core: accepts row words, presents a valid/ready window.
// Optional stall counter output enabled by defining SOBEL_ROWWIN_STALL_CNT_EN.
`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 2
`endif
`ifndef SOBEL_IDATA_WIDTH
`define SOBEL_IDATA_WIDTH ((`NUM_SOBEL_ACCELERATORS+2)*8)
`endif

module sobel_row_window #(
  parameter int unsigned ROWCNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ROWCNT_W-1:0]           img_rows,
  input  logic [`SOBEL_IDATA_WIDTH-1:0] mem2srow_data,
  input  logic                          mem2srow_valid,
  output logic                          srow2mem_ready,
  output logic [`SOBEL_IDATA_WIDTH-1:0] srow2sacc_row1_data,
  output logic [`SOBEL_IDATA_WIDTH-1:0] srow2sacc_row2_data,
  output logic [`SOBEL_IDATA_WIDTH-1:0] srow2sacc_row3_data,
  output logic                          srow2swt_valid,
  input  logic                          swt2srow_ready,
  output logic                          busy,
  output logic                          strip_done
`ifdef SOBEL_ROWWIN_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int unsigned DW = `SOBEL_IDATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL0 = 3'd1,
    S_FILL1 = 3'd2,
    S_FILL2 = 3'd3,
    S_VALID = 3'd4,
    S_SPENT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ROWCNT_W-1:0]   r_rows;
  logic [ROWCNT_W-1:0]   r_cnt;
  logic [DW-1:0]         r_row1;
  logic [DW-1:0]         r_row2;
  logic [DW-1:0]         r_row3;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_cnt_lt;
  logic                  w_ready;
  logic                  w_acc;
  logic                  w_cons;
  logic                  w_start;

  assign w_cnt_lt = (r_cnt < r_rows);
  assign w_ready  = ((r_state == S_FILL0) || (r_state == S_FILL1) || (r_state == S_FILL2) ||
                     (r_state == S_SPENT) || ((r_state == S_VALID) && swt2srow_ready)) && w_cnt_lt;
  assign w_acc    = w_ready && mem2srow_valid;
  assign w_cons   = (r_state == S_VALID) && swt2srow_ready;
  assign w_start  = (r_state == S_IDLE) && start;

  assign srow2mem_ready      = w_ready;
  assign srow2sacc_row1_data = r_row1;
  assign srow2sacc_row2_data = r_row2;
  assign srow2sacc_row3_data = r_row3;
  assign srow2swt_valid      = r_valid;
  assign busy                = r_busy;
  assign strip_done          = r_done;

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (img_rows >= ROWCNT_W'(3)) ? S_FILL0 : S_DONE;
      S_FILL0: if (w_acc) w_next = S_FILL1;
      S_FILL1: if (w_acc) w_next = S_FILL2;
      S_FILL2: if (w_acc) w_next = S_VALID;
      S_VALID: begin
        if (w_cons) begin
          if (!w_cnt_lt)  w_next = S_DONE;
          else if (w_acc) w_next = S_VALID;
          else            w_next = S_SPENT;
        end
      end
      S_SPENT: begin
        if (!w_cnt_lt)  w_next = S_DONE;
        else if (w_acc) w_next = S_VALID;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, flags registered from the next state, row shift on every accepted word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rows  <= '0;
      r_cnt   <= '0;
      r_row1  <= '0;
      r_row2  <= '0;
      r_row3  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == S_VALID);
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      if (w_start) begin
        r_rows <= img_rows;
        r_cnt  <= '0;
      end
      if (w_acc) begin
        r_row1 <= r_row2;
        r_row2 <= r_row3;
        r_row3 <= mem2srow_data;
        r_cnt  <= r_cnt + ROWCNT_W'(1);
      end
    end
  end

`ifdef SOBEL_ROWWIN_STALL_CNT_EN
  logic [31:0] r_stall;
  assign stall_cycles = r_stall;

  // Cycles a presented window waits on the write stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (w_start) begin
      r_stall <= '0;
    end else if ((r_state == S_VALID) && !swt2srow_ready && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_row_window.sv
// Directed self-checking bench for sobel_row_window.
`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 2
`endif
`ifndef SOBEL_IDATA_WIDTH
`define SOBEL_IDATA_WIDTH ((`NUM_SOBEL_ACCELERATORS+2)*8)
`endif

module tb_sobel_row_window;
  localparam int unsigned DW = `SOBEL_IDATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [15:0]   img_rows;
  logic [DW-1:0] mem2srow_data;
  logic          mem2srow_valid;
  logic          srow2mem_ready;
  logic [DW-1:0] row1, row2, row3;
  logic          srow2swt_valid;
  logic          swt2srow_ready;
  logic          busy;
  logic          strip_done;
`ifdef SOBEL_ROWWIN_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sobel_row_window #(.ROWCNT_W(16)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .img_rows            (img_rows),
    .mem2srow_data       (mem2srow_data),
    .mem2srow_valid      (mem2srow_valid),
    .srow2mem_ready      (srow2mem_ready),
    .srow2sacc_row1_data (row1),
    .srow2sacc_row2_data (row2),
    .srow2sacc_row3_data (row3),
    .srow2swt_valid      (srow2swt_valid),
    .swt2srow_ready      (swt2srow_ready),
    .busy                (busy),
    .strip_done          (strip_done)
`ifdef SOBEL_ROWWIN_STALL_CNT_EN
    ,
    .stall_cycles        (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ready, valid, busy, done in one packed vector
  function automatic logic [3:0] flags();
    return {srow2mem_ready, srow2swt_valid, busy, strip_done};
  endfunction

  task automatic chk_win(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c);
    chk({tag, "_r1"}, 64'(row1), 64'(a));
    chk({tag, "_r2"}, 64'(row2), 64'(b));
    chk({tag, "_r3"}, 64'(row3), 64'(c));
  endtask

  localparam logic [DW-1:0] RA = 32'hA0A0_0001, RB = 32'hB0B0_0002, RC = 32'hC0C0_0003;
  localparam logic [DW-1:0] RD = 32'hD0D0_0004, RE = 32'hE0E0_0005;
  localparam logic [DW-1:0] RP = 32'h1111_1111, RQ = 32'h2222_2222, RR = 32'h3333_3333;
  localparam logic [DW-1:0] RS = 32'h4444_4444, RJ = 32'hDEAD_BEEF;

  initial begin
    reset_n = 1'b0; start = 1'b0; img_rows = '0;
    mem2srow_data = '0; mem2srow_valid = 1'b0; swt2srow_ready = 1'b0;
    step(); step();
    chk("rst_flags", 64'(flags()), 64'(4'b0000));
    chk_win("rst", '0, '0, '0);
    reset_n = 1'b1;
    step();

    // 5-row strip, write stage always ready; consume+accept in VALID keeps valid high
    img_rows = 16'd5; start = 1'b1; swt2srow_ready = 1'b1;
    step();
    start = 1'b0;
    chk("s5_fill0_flags", 64'(flags()), 64'(4'b1010));
    mem2srow_valid = 1'b1; mem2srow_data = RA; step();
    mem2srow_data = RB; step();
    chk("s5_fill2_flags", 64'(flags()), 64'(4'b1010));
    mem2srow_data = RC; step();
    chk("s5_w1_flags", 64'(flags()), 64'(4'b1110));
    chk_win("s5_w1", RA, RB, RC);
    mem2srow_data = RD; step();
    chk("s5_w2_flags", 64'(flags()), 64'(4'b1110));
    chk_win("s5_w2", RB, RC, RD);
    mem2srow_data = RE; step();
    chk("s5_w3_flags", 64'(flags()), 64'(4'b0110));
    chk_win("s5_w3", RC, RD, RE);
    mem2srow_data = RJ; step();
    chk("s5_done_flags", 64'(flags()), 64'(4'b0011));
    chk_win("s5_done", RC, RD, RE);
    step();
    chk("s5_idle_flags", 64'(flags()), 64'(4'b0000));
    chk_win("s5_idle", RC, RD, RE);
    mem2srow_valid = 1'b0;

    // 4-row strip with 10 stalled cycles; restart attempt with 9 rows mid-strip is ignored
    img_rows = 16'd4; start = 1'b1; swt2srow_ready = 1'b0;
    step();
    start = 1'b0;
    mem2srow_valid = 1'b1; mem2srow_data = RP; step();
    mem2srow_data = RQ; step();
    mem2srow_data = RR; step();
    chk("bp_valid_flags", 64'(flags()), 64'(4'b0110));
    chk_win("bp_w1", RP, RQ, RR);
    mem2srow_data = RS;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin start = 1'b1; img_rows = 16'd9; end
      else start = 1'b0;
      step();
    end
    start = 1'b0;
    chk("bp_held_flags", 64'(flags()), 64'(4'b0110));
    chk_win("bp_held", RP, RQ, RR);
`ifdef SOBEL_ROWWIN_STALL_CNT_EN
    chk("bp_stall10", 64'(stall_cycles), 64'd10);
`endif
    swt2srow_ready = 1'b1; #1;
    chk("bp_release_ready", 64'(srow2mem_ready), 64'd1);
    step();
    chk("bp_w2_flags", 64'(flags()), 64'(4'b0110));
    chk_win("bp_w2", RQ, RR, RS);
    mem2srow_data = RJ; step();
    chk("bp_done_flags", 64'(flags()), 64'(4'b0011));
    step();
    chk("bp_idle_flags", 64'(flags()), 64'(4'b0000));
    chk_win("bp_idle", RQ, RR, RS);
`ifdef SOBEL_ROWWIN_STALL_CNT_EN
    chk("bp_stall_hold", 64'(stall_cycles), 64'd10);
`endif
    mem2srow_valid = 1'b0;

    // Short strip: no rows, no windows, one-cycle done
    img_rows = 16'd2; start = 1'b1;
    #1;
    chk("s2_idle_ready", 64'(srow2mem_ready), 64'd0);
    step();
    start = 1'b0;
    chk("s2_done_flags", 64'(flags()), 64'(4'b0011));
`ifdef SOBEL_ROWWIN_STALL_CNT_EN
    chk("s2_stall_clr", 64'(stall_cycles), 64'd0);
`endif
    step();
    chk("s2_idle_flags", 64'(flags()), 64'(4'b0000));

    // Asynchronous reset in the middle of FILL1
    img_rows = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    mem2srow_valid = 1'b1; mem2srow_data = RA; step();
    mem2srow_valid = 1'b0;
    chk("ar_fill1_flags", 64'(flags()), 64'(4'b1010));
    chk("ar_fill1_row3", 64'(row3), 64'(RA));
    #2 reset_n = 1'b0;
    #1;
    chk("ar_flags", 64'(flags()), 64'(4'b0000));
    chk_win("ar", '0, '0, '0);
    step();
    reset_n = 1'b1;
    mem2srow_valid = 1'b1; mem2srow_data = RB;
    step();
    chk("ar_after_flags", 64'(flags()), 64'(4'b0000));
    chk("ar_after_row3", 64'(row3), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
